ahb_arbiter_nway: RTL and testbench

//  Parametrised N-master front end that presents translation walker, D-cache, I-cache (and future

---
 rtl/ahb_arbiter_nway_pkg.sv | 19 +
 rtl/ahb_arbiter_nway_if.sv | 32 +++
 rtl/ahb_arbiter_nway_picker.sv | 45 ++++
 rtl/ahb_arbiter_nway.sv | 107 ++++++++++
 tb/tb_ahb_arbiter_nway.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_arbiter_nway_pkg.sv
// Shared types for the N-way AHB-Lite master arbiter: FSM state encoding,
// HSIZE encodings and an index-width helper.
package ahb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } arb_state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Width of a master index; never zero so NM=1 still yields a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_arbiter_nway_if.sv
// Bus bundle between the requesting masters, the arbiter and the AHB-Lite slave side.
// The master modport is the arbiter acting as the single bus master; slave is its environment.
interface ahb_arbiter_nway_if #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                    HReady;
    logic [NM-1:0]           HReqIn;
    logic [NM-1:0]           HWriteIn;
    logic [NM-1:0][2:0]      HSizeIn;
    logic [NM-1:0][AW-1:0]   HAddrIn;
    logic [NM-1:0][DW-1:0]   HWDataIn;
    logic [NM-1:0]           HReadyOut;
    logic [NM-1:0]           Sel;
    logic                    HRequest;
    logic                    HWrite;
    logic [2:0]              HSIZE;
    logic [AW-1:0]           HAddr;
    logic [DW-1:0]           HWData;

    modport master (
        input  HReady, HReqIn, HWriteIn, HSizeIn, HAddrIn, HWDataIn,
        output HReadyOut, Sel, HRequest, HWrite, HSIZE, HAddr, HWData
    );

    modport slave (
        output HReady, HReqIn, HWriteIn, HSizeIn, HAddrIn, HWDataIn,
        input  HReadyOut, Sel, HRequest, HWrite, HSIZE, HAddr, HWData
    );

endinterface

// File: rtl/ahb_arbiter_nway_picker.sv
// Grant picker: eligible request vector -> one-hot winner. Lowest index wins by default;
// with ARB_ROUND_ROBIN_EN defined the search starts at rr_ptr and wraps, and the index is output.
module ahb_arb_picker
    import ahb_arb_pkg::*;
#(
    parameter int NM = 3
`ifdef ARB_ROUND_ROBIN_EN
    , parameter int IW = idx_w(NM)
`endif
) (
    input  logic [NM-1:0] eligible,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] win_idx,
`endif
    output logic [NM-1:0] winner
);

    logic [NM-1:0] cand;

    always_comb begin
        cand   = eligible;
        winner = '0;
`ifdef ARB_ROUND_ROBIN_EN
        win_idx = '0;
        // Mask off indices below the pointer; fall back to the full set to wrap around.
        for (int i = 0; i < NM; i++) begin
            cand[i] = eligible[i] & (IW'(i) >= rr_ptr);
        end
        if (!(|cand)) begin
            cand = eligible;
        end
`endif
        for (int i = NM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                win_idx   = IW'(i);
`endif
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_nway.sv
// N-master AHB-Lite front end: overlaps the next address phase with the current data phase.
// Fixed priority by default; define ARB_ROUND_ROBIN_EN for round-robin grant.
module ahb_arbiter_nway
    import ahb_arb_pkg::*;
#(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                reset,
    ahb_arbiter_nway_if.master  bus
);

    arb_state_t    state_p1, state_nx;
    logic [NM-1:0] owner_p1, owner_nx;
    logic [NM-1:0] eligible, pick, winner;
    logic          vld_p1, adv;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [2:0]    size_mux;
    logic          write_mux;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int IW = idx_w(NM);
    logic [IW-1:0] rr_ptr_p1, rr_ptr_nx, win_idx;

    ahb_arb_picker #(.NM(NM), .IW(IW)) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_p1),
        .win_idx  (win_idx),
        .winner   (pick)
    );
`else
    ahb_arb_picker #(.NM(NM)) u_picker (
        .eligible (eligible),
        .winner   (pick)
    );
`endif

    always_comb begin
        vld_p1   = (state_p1 == DATA);
        adv      = !vld_p1 || bus.HReady;
        // The data-phase owner may still hold its request; never grant it twice.
        eligible = bus.HReqIn & ~(vld_p1 ? owner_p1 : '0);
        winner   = (adv && reset) ? pick : '0;

        state_nx = state_p1;
        owner_nx = owner_p1;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_nx = rr_ptr_p1;
`endif
        if (adv) begin
            if (|winner) begin
                state_nx = DATA;
                owner_nx = winner;
`ifdef ARB_ROUND_ROBIN_EN
                rr_ptr_nx = (win_idx == IW'(NM - 1)) ? '0 : win_idx + IW'(1);
`endif
            end else begin
                state_nx = IDLE;
                owner_nx = '0;
            end
        end

        addr_mux  = '0;
        size_mux  = '0;
        write_mux = 1'b0;
        wdata_mux = '0;
        for (int i = 0; i < NM; i++) begin
            if (winner[i]) begin
                addr_mux  = addr_mux  | bus.HAddrIn[i];
                size_mux  = size_mux  | bus.HSizeIn[i];
                write_mux = write_mux | bus.HWriteIn[i];
            end
            if (owner_p1[i]) begin
                wdata_mux = wdata_mux | bus.HWDataIn[i];
            end
        end
    end

    // ---- stage boundary: address phase -> data phase ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1  <= IDLE;
            owner_p1  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_p1 <= '0;
`endif
        end else begin
            state_p1  <= state_nx;
            owner_p1  <= owner_nx;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_p1 <= rr_ptr_nx;
`endif
        end
    end

    assign bus.HRequest  = |winner;
    assign bus.HAddr     = addr_mux;
    assign bus.HSIZE     = size_mux;
    assign bus.HWrite    = write_mux;
    assign bus.HWData    = wdata_mux;
    assign bus.Sel       = owner_p1;
    assign bus.HReadyOut = vld_p1 ? (owner_p1 & {NM{bus.HReady}}) : '0;

endmodule

// File: tb/tb_ahb_arbiter_nway.sv
// Table-driven bench for ahb_arbiter_nway (NM=4) with a grant/completion scoreboard;
// expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_ahb_arbiter_nway;
    import ahb_arb_pkg::*;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ahb_arbiter_nway_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

    ahb_arbiter_nway #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          rst_n;
        logic [NM-1:0] req;
        logic          hready;
        logic [NM-1:0] win;
        logic [NM-1:0] rdy;
        logic [NM-1:0] sel;
        string         tag;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h4000_0000 + 32'(i) * 32'h0000_1010 + 32'h4;
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0101_0101 + 32'h1;
    endfunction

    function automatic logic write_of(input int i);
        return (i % 2) == 1;
    endfunction

    function automatic logic [2:0] size_of(input int i);
        case (i % 3)
            0:       return HSIZE_BYTE;
            1:       return HSIZE_HALF;
            default: return HSIZE_WORD;
        endcase
    endfunction

    function automatic int idx_of(input logic [NM-1:0] oh);
        for (int i = 0; i < NM; i++) if (oh[i]) return i;
        return -1;
    endfunction

    function automatic logic [NM-1:0] onehot(input int i);
        logic [NM-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [NM-1:0] q, input logic h,
                       input logic [NM-1:0] w, input logic [NM-1:0] d,
                       input logic [NM-1:0] s, input string t);
        vecs.push_back('{rst_n: r, req: q, hready: h, win: w, rdy: d, sel: s, tag: t});
    endtask

    task automatic check_outputs(input string t, input logic [NM-1:0] w,
                                 input logic [NM-1:0] d, input logic [NM-1:0] s);
        int wi, si;
        wi = idx_of(w);
        si = idx_of(s);
        check({t, " HRequest"},  64'(bus.HRequest),  64'(|w));
        check({t, " HAddr"},     64'(bus.HAddr),     (wi < 0) ? 64'd0 : 64'(addr_of(wi)));
        check({t, " HWrite"},    64'(bus.HWrite),    (wi < 0) ? 64'd0 : 64'(write_of(wi)));
        check({t, " HSIZE"},     64'(bus.HSIZE),     (wi < 0) ? 64'd0 : 64'(size_of(wi)));
        check({t, " HReadyOut"}, 64'(bus.HReadyOut), 64'(d));
        check({t, " Sel"},       64'(bus.Sel),       64'(s));
        check({t, " HWData"},    64'(bus.HWData),    (si < 0) ? 64'd0 : 64'(data_of(si)));
    endtask

    initial begin
        reset        = 1'b0;
        bus.HReady   = 1'b1;
        bus.HReqIn   = '0;
        for (int i = 0; i < NM; i++) begin
            bus.HWriteIn[i] = write_of(i);
            bus.HSizeIn[i]  = size_of(i);
            bus.HAddrIn[i]  = addr_of(i);
            bus.HWDataIn[i] = data_of(i);
        end

        //  rst  req    hr   win    rdy    sel
        add(0, 4'b0111, 1, 4'b0000, 4'b0000, 4'b0000, "rst_hold0");
        add(0, 4'b0111, 1, 4'b0000, 4'b0000, 4'b0000, "rst_hold1");
        add(1, 4'b0111, 1, 4'b0001, 4'b0000, 4'b0000, "rel_grant0");
        add(1, 4'b0111, 1, 4'b0010, 4'b0001, 4'b0001, "rel_grant1");
        add(1, 4'b0100, 1, 4'b0100, 4'b0010, 4'b0010, "rel_grant2");
        add(1, 4'b0000, 1, 4'b0000, 4'b0100, 4'b0100, "rel_drain");
        add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "rel_idle");

        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "con_rst");
        add(1, 4'b0110, 1, 4'b0010, 4'b0000, 4'b0000, "con_c0");
        add(1, 4'b0110, 1, 4'b0100, 4'b0010, 4'b0010, "con_c1");
        add(1, 4'b0100, 1, 4'b0000, 4'b0100, 4'b0100, "con_c2");
        add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "con_idle");

        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "ws_rst");
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0000, "ws_grant2");
        add(1, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0100, "ws_stall0");
        add(1, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0100, "ws_stall1");
        add(1, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0100, "ws_stall2");
        add(1, 4'b0101, 1, 4'b0001, 4'b0100, 4'b0100, "ws_release");
        add(1, 4'b0001, 1, 4'b0000, 4'b0001, 4'b0001, "ws_done0");
        add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "ws_idle");

        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "hold_rst");
        add(1, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, "hold_issue1");
        add(1, 4'b0001, 1, 4'b0000, 4'b0001, 4'b0001, "hold_done1");
        add(1, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, "hold_issue2");
        add(1, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, "hold_wait2");
        add(1, 4'b0001, 1, 4'b0000, 4'b0001, 4'b0001, "hold_done2");
        add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "hold_idle");

        add(0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, "all_rst");
`ifdef ARB_ROUND_ROBIN_EN
        add(1, 4'b1111, 1, 4'b0001, 4'b0000, 4'b0000, "rr_c0");
        add(1, 4'b1111, 1, 4'b0010, 4'b0001, 4'b0001, "rr_c1");
        add(1, 4'b1111, 1, 4'b0100, 4'b0010, 4'b0010, "rr_c2");
        add(1, 4'b1111, 1, 4'b1000, 4'b0100, 4'b0100, "rr_c3");
        add(1, 4'b1111, 1, 4'b0001, 4'b1000, 4'b1000, "rr_c4");
`else
        add(1, 4'b1111, 1, 4'b0001, 4'b0000, 4'b0000, "fp_c0");
        add(1, 4'b1111, 1, 4'b0010, 4'b0001, 4'b0001, "fp_c1");
        add(1, 4'b1111, 1, 4'b0001, 4'b0010, 4'b0010, "fp_c2");
        add(1, 4'b1111, 1, 4'b0010, 4'b0001, 4'b0001, "fp_c3");
        add(1, 4'b1111, 1, 4'b0001, 4'b0010, 4'b0010, "fp_c4");
`endif
        add(1, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0001, "all_drain");
        add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "all_idle");

        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "mid_rst0");
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0000, "mid_grant2");
        add(1, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0100, "mid_stall");
        add(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, "mid_abort");
        add(1, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0000, "mid_restart");
        add(1, 4'b0100, 1, 4'b0000, 4'b0100, 4'b0100, "mid_done");
        add(1, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, "mid_idle");

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            v = vecs[k];
            @(posedge clk);
            #1;
            reset      = v.rst_n;
            bus.HReqIn = v.req;
            bus.HReady = v.hready;
            if (!v.rst_n) exp_q.delete();
            if (|v.win) exp_q.push_back(idx_of(v.win));
            @(negedge clk);
            check_outputs(v.tag, v.win, v.rdy, v.sel);
            if (|bus.HReadyOut) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL %s sb: got HReadyOut %0h, expected no completion", v.tag, bus.HReadyOut);
                end else begin
                    int m;
                    m = exp_q.pop_front();
                    check({v.tag, " sb"}, 64'(bus.HReadyOut), 64'(onehot(m)));
                end
            end
        end
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted between clock edges while a write is stalled in its data phase.
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.HReqIn = 4'b1000;
        bus.HReady = 1'b1;
        @(negedge clk);
        check("async_issue HAddr", 64'(bus.HAddr), 64'(addr_of(3)));
        check("async_issue HWrite", 64'(bus.HWrite), 64'd1);
        @(posedge clk);
        #1;
        bus.HReady = 1'b0;
        @(negedge clk);
        check("async_stall Sel", 64'(bus.Sel), 64'(4'b1000));
        check("async_stall HWData", 64'(bus.HWData), 64'(data_of(3)));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst Sel", 64'(bus.Sel), 64'd0);
        check("async_rst HReadyOut", 64'(bus.HReadyOut), 64'd0);
        check("async_rst HRequest", 64'(bus.HRequest), 64'd0);
        check("async_rst HAddr", 64'(bus.HAddr), 64'd0);
        check("async_rst HWData", 64'(bus.HWData), 64'd0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.HReqIn = '0;
        bus.HReady = 1'b1;
        @(negedge clk);
        check("async_rel Sel", 64'(bus.Sel), 64'd0);
        check("async_rel HReadyOut", 64'(bus.HReadyOut), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
